// File: rtl/bcm_scan_sequencer.sv
// Binary-code-modulation scan sequencer for an LED matrix.
// Drives the panel row address, latch and output-enable, commands the column
// shifter one row/plane ahead so shifting overlaps display, and starts the
// downstream timeout counter with the display period of each bit plane.
//
// state   | meaning
// --------+-----------------------------------------------------------------
// IDLE    | not running; enable launches a shift of the retained next address
// SHIFT   | first shift of a run in flight, display dark
// BLANK   | one dark cycle between planes (ghost guard)
// LATCH   | latch pulse, address copied to panel, timeout started
// DISPLAY | panel lit until timeout expires
// WAIT    | period over but the next shift is still outstanding, display dark
module bcm_scan_sequencer #(
  parameter int ROW_WIDTH     = 4,
  parameter int PLANES        = 8,
  parameter int PLANE_WIDTH   = 3,
  parameter int COUNTER_WIDTH = 12,
  parameter int BASE_TIME     = 8
) (
  input  logic                     i_clk_in,
  input  logic                     i_reset,
  input  logic                     i_enable,
  output logic                     o_shift_start,
  output logic [ROW_WIDTH-1:0]     o_shift_row,
  output logic [PLANE_WIDTH-1:0]   o_shift_plane,
  input  logic                     i_shift_done,
  output logic [ROW_WIDTH-1:0]     o_row_addr,
  output logic [PLANE_WIDTH-1:0]   o_bit_plane,
  output logic                     o_output_latch,
  output logic                     o_output_enable,
  output logic                     o_timeout_start,
  output logic [COUNTER_WIDTH-1:0] o_timeout_value,
  input  logic                     i_timeout_running,
  output logic                     o_frame_done
);

  localparam logic [PLANE_WIDTH-1:0]   LP_LAST_PLANE = PLANE_WIDTH'(PLANES - 1);
  localparam logic [COUNTER_WIDTH-1:0] LP_BASE       = COUNTER_WIDTH'(BASE_TIME);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_SHIFT   = 3'd1,
    S_BLANK   = 3'd2,
    S_LATCH   = 3'd3,
    S_DISPLAY = 3'd4,
    S_WAIT    = 3'd5
  } state_t;

  state_t r_state;
  logic   r_shift_pend;   // a shift_start has been issued, its shift_done not yet seen
  logic   r_shift_rcvd;   // shift_done for the upcoming plane already arrived
  logic   r_first_disp;   // first DISPLAY cycle, timeout_running not yet valid

  logic                     w_done_cnt;
  logic                     w_last_plane;
  logic                     w_last_row;
  logic [ROW_WIDTH-1:0]     w_next_row;
  logic [PLANE_WIDTH-1:0]   w_next_plane;
  logic [COUNTER_WIDTH-1:0] w_period;

  // shift_done only matters while a shift is outstanding
  assign w_done_cnt   = r_shift_pend & i_shift_done;
  assign w_last_plane = (o_shift_plane == LP_LAST_PLANE);
  assign w_last_row   = &o_shift_row;
  assign w_next_plane = w_last_plane ? '0 : o_shift_plane + PLANE_WIDTH'(1);
  assign w_next_row   = w_last_plane ? o_shift_row + ROW_WIDTH'(1) : o_shift_row;
  assign w_period     = LP_BASE << o_shift_plane;

  // sequencer FSM with all outputs registered
  always_ff @(posedge i_clk_in or posedge i_reset) begin
    if (i_reset) begin
      r_state         <= S_IDLE;
      r_shift_pend    <= 1'b0;
      r_shift_rcvd    <= 1'b0;
      r_first_disp    <= 1'b0;
      o_shift_start   <= 1'b0;
      o_shift_row     <= '0;
      o_shift_plane   <= '0;
      o_row_addr      <= '0;
      o_bit_plane     <= '0;
      o_output_latch  <= 1'b0;
      o_output_enable <= 1'b0;
      o_timeout_start <= 1'b0;
      o_timeout_value <= '0;
      o_frame_done    <= 1'b0;
    end else begin
      o_shift_start   <= 1'b0;
      o_output_latch  <= 1'b0;
      o_timeout_start <= 1'b0;
      o_frame_done    <= 1'b0;

      if (w_done_cnt) begin
        r_shift_pend <= 1'b0;
        r_shift_rcvd <= 1'b1;
      end

      case (r_state)
        S_IDLE: begin
          o_output_enable <= 1'b0;
          if (i_enable) begin
            // restart from the retained address without advancing it
            o_shift_start <= 1'b1;
            r_shift_pend  <= 1'b1;
            r_shift_rcvd  <= 1'b0;
            r_state       <= S_SHIFT;
          end
        end

        S_SHIFT: begin
          if (w_done_cnt) r_state <= S_BLANK;
        end

        S_BLANK: begin
          o_output_latch  <= 1'b1;
          o_row_addr      <= o_shift_row;
          o_bit_plane     <= o_shift_plane;
          o_timeout_value <= w_period;
          o_timeout_start <= 1'b1;
          o_frame_done    <= w_last_row & w_last_plane;
          r_shift_rcvd    <= 1'b0;
          r_state         <= S_LATCH;
        end

        S_LATCH: begin
          o_output_enable <= 1'b1;
          r_first_disp    <= 1'b1;
          if (i_enable) begin
            o_shift_start <= 1'b1;
            o_shift_row   <= w_next_row;
            o_shift_plane <= w_next_plane;
            r_shift_pend  <= 1'b1;
            r_shift_rcvd  <= 1'b0;
          end
          r_state <= S_DISPLAY;
        end

        S_DISPLAY: begin
          r_first_disp <= 1'b0;
          if (!r_first_disp && !i_timeout_running) begin
            o_output_enable <= 1'b0;
            if (r_shift_rcvd || w_done_cnt) r_state <= S_BLANK;
            else if (!r_shift_pend)         r_state <= S_IDLE;
            else                            r_state <= S_WAIT;
          end
        end

        S_WAIT: begin
          if (w_done_cnt) r_state <= S_BLANK;
        end

        default: begin
          o_output_enable <= 1'b0;
          r_state         <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bcm_scan_sequencer.sv
// Scoreboard bench for bcm_scan_sequencer with behavioural shifter and
// timeout models; expected shifts and latches are queued by the stimulus
// and consumed by a monitor on the opposite clock edge.
`timescale 1ns/1ps
module tb_bcm_scan_sequencer;

  localparam int RW = 4;
  localparam int PL = 8;
  localparam int PW = 3;
  localparam int CW = 12;
  localparam int BT = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          en  = 1'b0;
  logic          shift_done;
  logic          tmo_running;
  logic          shift_start;
  logic [RW-1:0] shift_row;
  logic [PW-1:0] shift_plane;
  logic [RW-1:0] row_addr;
  logic [PW-1:0] bit_plane;
  logic          out_latch;
  logic          out_en;
  logic          tmo_start;
  logic [CW-1:0] tmo_value;
  logic          frame_done;

  bcm_scan_sequencer #(
    .ROW_WIDTH(RW), .PLANES(PL), .PLANE_WIDTH(PW),
    .COUNTER_WIDTH(CW), .BASE_TIME(BT)
  ) dut (
    .i_clk_in(clk), .i_reset(rst), .i_enable(en),
    .o_shift_start(shift_start), .o_shift_row(shift_row), .o_shift_plane(shift_plane),
    .i_shift_done(shift_done), .o_row_addr(row_addr), .o_bit_plane(bit_plane),
    .o_output_latch(out_latch), .o_output_enable(out_en),
    .o_timeout_start(tmo_start), .o_timeout_value(tmo_value),
    .i_timeout_running(tmo_running), .o_frame_done(frame_done)
  );

  always #5 clk = ~clk;

  typedef struct { logic [RW-1:0] row; logic [PW-1:0] plane; } shift_t;
  typedef struct { logic [RW-1:0] row; logic [PW-1:0] plane; logic [CW-1:0] tval; logic fd; int gap; } latch_t;

  shift_t q_shift[$];
  latch_t q_latch[$];

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int lat_cnt = 0;
  int fd_cnt = 0;
  int shift_delay = 4;

  always @(posedge clk) cyc <= cyc + 1;

  // column shifter: shift_done arrives shift_delay+1 cycles after shift_start
  int sh_cnt;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      sh_cnt <= 0;
      shift_done <= 1'b0;
    end else begin
      shift_done <= 1'b0;
      if (shift_start) sh_cnt <= shift_delay;
      else if (sh_cnt != 0) begin
        sh_cnt <= sh_cnt - 1;
        if (sh_cnt == 1) shift_done <= 1'b1;
      end
    end
  end

  // timeout block: loads on rising edge of start, running while count is nonzero
  logic [CW-1:0] tm_cnt;
  logic          tm_start_d;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      tm_cnt <= '0;
      tm_start_d <= 1'b0;
    end else begin
      tm_start_d <= tmo_start;
      if (tmo_start && !tm_start_d) tm_cnt <= tmo_value;
      else if (tm_cnt != 0) tm_cnt <= tm_cnt - 1'b1;
    end
  end
  assign tmo_running = (tm_cnt != 0);

  task automatic push_shift(input int r, input int p);
    shift_t s;
    s.row = RW'(r);
    s.plane = PW'(p);
    q_shift.push_back(s);
  endtask

  task automatic push_latch(input int r, input int p, input int gap);
    latch_t l;
    l.row = RW'(r);
    l.plane = PW'(p);
    l.tval = CW'(BT << p);
    l.fd = (r == 15 && p == 7);
    l.gap = gap;
    q_latch.push_back(l);
  endtask

  task automatic wait_latch(input int target, input int budget);
    int n = 0;
    while (lat_cnt < target && n < budget) begin
      @(posedge clk);
      n++;
    end
    checks++;
    if (lat_cnt < target) begin
      errors++;
      $display("FAIL wait_latch: got %0d latches, want %0d within %0d cycles", lat_cnt, target, budget);
    end
  endtask

  task automatic check_all_zero(input string name);
    checks++;
    if ({shift_start, shift_row, shift_plane, row_addr, bit_plane, out_latch,
         out_en, tmo_start, tmo_value, frame_done} !== '0) begin
      errors++;
      $display("FAIL %s: outputs not zero (ss=%0b sr=%0d sp=%0d row=%0d pl=%0d lat=%0b oe=%0b ts=%0b tv=%0d fd=%0b)",
               name, shift_start, shift_row, shift_plane, row_addr, bit_plane, out_latch,
               out_en, tmo_start, tmo_value, frame_done);
    end
  endtask

  // monitor: pops expectations as the DUT presents shifts and latches
  initial begin
    int oe_cnt, exp_w, last_lat;
    logic oe_prev;
    logic [RW-1:0] row_prev;
    shift_t s;
    latch_t l;
    oe_cnt = 0; exp_w = 0; last_lat = -1; oe_prev = 1'b0; row_prev = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        oe_cnt = 0; oe_prev = 1'b0; row_prev = row_addr; last_lat = -1;
      end else begin
        if (shift_start) begin
          checks++;
          if (q_shift.size() == 0) begin
            errors++;
            $display("FAIL shift_unexpected: got row=%0d plane=%0d, want no shift", shift_row, shift_plane);
          end else begin
            s = q_shift.pop_front();
            if (shift_row !== s.row || shift_plane !== s.plane) begin
              errors++;
              $display("FAIL shift_addr: got row=%0d plane=%0d, want row=%0d plane=%0d",
                       shift_row, shift_plane, s.row, s.plane);
            end
          end
        end
        if (out_latch) begin
          checks++;
          lat_cnt++;
          if (q_latch.size() == 0) begin
            errors++;
            $display("FAIL latch_unexpected: got row=%0d plane=%0d, want no latch", row_addr, bit_plane);
          end else begin
            l = q_latch.pop_front();
            exp_w = 1 + (BT << l.plane);
            if ({row_addr, bit_plane, tmo_value, frame_done, tmo_start, out_en} !==
                {l.row, l.plane, l.tval, l.fd, 1'b1, 1'b0}) begin
              errors++;
              $display("FAIL latch_fields: got row=%0d plane=%0d tv=%0d fd=%0b ts=%0b oe=%0b, want row=%0d plane=%0d tv=%0d fd=%0b ts=1 oe=0",
                       row_addr, bit_plane, tmo_value, frame_done, tmo_start, out_en,
                       l.row, l.plane, l.tval, l.fd);
            end
            if (l.gap != 0) begin
              checks++;
              if (cyc - last_lat != l.gap) begin
                errors++;
                $display("FAIL latch_gap: got %0d cycles, want %0d", cyc - last_lat, l.gap);
              end
            end
          end
          last_lat = cyc;
        end
        if (frame_done) begin
          fd_cnt++;
          checks++;
          if (!out_latch) begin
            errors++;
            $display("FAIL frame_done_pos: got frame_done outside latch, want only with latch");
          end
        end
        if (tmo_start) begin
          checks++;
          if (!out_latch) begin
            errors++;
            $display("FAIL timeout_start_pos: got start outside latch, want only with latch");
          end
        end
        if (row_addr !== row_prev) begin
          checks++;
          if (!out_latch || out_en) begin
            errors++;
            $display("FAIL row_change: got change with lat=%0b oe=%0b, want lat=1 oe=0", out_latch, out_en);
          end
        end
        row_prev = row_addr;
        if (out_en) oe_cnt++;
        else if (oe_prev) begin
          checks++;
          if (oe_cnt != exp_w) begin
            errors++;
            $display("FAIL oe_width: got %0d cycles, want %0d", oe_cnt, exp_w);
          end
          oe_cnt = 0;
        end
        oe_prev = out_en;
      end
    end
  end

  // stimulus
  initial begin
    int gap;
    repeat (3) @(negedge clk);
    check_all_zero("reset_outputs");
    rst = 1'b0;

    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check_all_zero("idle_outputs");
    end

    // free run: one full frame plus the first 30 latches of the next
    push_shift(0, 0);
    for (int i = 0; i <= 157; i++) begin
      if (i == 0) gap = 0;
      else if (i == 129) gap = 2000 + 4;
      else gap = (BT << ((i - 1) % 8)) + 3;
      push_latch((i / 8) % 16, i % 8, gap);
      push_shift(((i + 1) / 8) % 16, (i + 1) % 8);
    end
    push_latch(3, 6, (BT << 5) + 3);

    @(negedge clk);
    en = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (shift_start !== 1'b1) begin
      errors++;
      $display("FAIL start_latency: got shift_start=%0b, want 1", shift_start);
    end

    // slow shifter for the shift following the second (0,0) latch
    wait_latch(129, 40000);
    shift_delay = 2000;
    checks++;
    if (fd_cnt != 1) begin
      errors++;
      $display("FAIL frame_count: got %0d frame_done pulses, want 1", fd_cnt);
    end
    @(posedge clk);
    @(negedge clk);
    shift_delay = 4;
    repeat (1200) @(negedge clk);
    checks++;
    if (out_en !== 1'b0 || out_latch !== 1'b0) begin
      errors++;
      $display("FAIL wait_dark: got oe=%0b lat=%0b, want oe=0 lat=0", out_en, out_latch);
    end

    // drop enable while (3,5) is displayed
    wait_latch(158, 12000);
    repeat (20) @(negedge clk);
    en = 1'b0;
    wait_latch(159, 2000);
    repeat (600) @(negedge clk);
    checks++;
    if (out_en !== 1'b0 || shift_row !== 4'd3 || shift_plane !== 3'd6) begin
      errors++;
      $display("FAIL disable_idle: got oe=%0b next=(%0d,%0d), want oe=0 next=(3,6)", out_en, shift_row, shift_plane);
    end

    // re-enable resumes from the retained address
    push_shift(3, 6);
    push_latch(3, 6, 0);
    push_shift(3, 7);
    en = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (shift_start !== 1'b1) begin
      errors++;
      $display("FAIL reenable_latency: got shift_start=%0b, want 1", shift_start);
    end

    // asynchronous reset mid-display
    wait_latch(160, 500);
    repeat (30) @(negedge clk);
    checks++;
    if (out_en !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset_oe: got oe=%0b, want 1", out_en);
    end
    #2;
    rst = 1'b1;
    en = 1'b0;
    #1;
    check_all_zero("async_reset");
    repeat (3) @(negedge clk);
    rst = 1'b0;

    push_shift(0, 0);
    push_latch(0, 0, 0);
    push_shift(0, 1);
    push_latch(0, 1, BT + 3);
    push_shift(0, 2);
    @(negedge clk);
    en = 1'b1;
    wait_latch(162, 500);
    repeat (5) @(negedge clk);
    checks++;
    if (q_shift.size() != 0 || q_latch.size() != 0) begin
      errors++;
      $display("FAIL queues_drained: got shifts=%0d latches=%0d pending, want 0 0", q_shift.size(), q_latch.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
